// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO pop interface into a valid/ready stream through a 2-entry buffer.
// Optional macro FIFO_READER_STATS_EN adds o_starve_cycles (saturating count of cycles ready but not valid).
module fifo_stream_reader #(
    parameter int WORD_LENGTH  = 8,
    parameter int READ_LATENCY = 0,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [WORD_LENGTH-1:0] i_fifo_data,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_read_en,
    output logic [WORD_LENGTH-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    input  logic                   i_flush,
    output logic [COUNT_WIDTH-1:0] o_count
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] o_starve_cycles
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
    occ_t state, state_n;
    logic inflight, pop_out, capture;
    logic [1:0] load, after;
    logic [WORD_LENGTH-1:0] head, tail, head_n, tail_n;
    // occupancy register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= EMPTY;
        else state <= state_n;
    end
    // occupancy after this edge's transfer and capture; flush empties the buffer
    always_comb begin
        state_n = i_flush ? EMPTY : occ_t'(2'(state) - 2'(pop_out) + 2'(capture));
    end
    // stream outputs, credit-checked pop request, and buffer write steering
    always_comb begin
        o_valid        = state != EMPTY;
        o_data         = head;
        pop_out        = o_valid && i_ready;
        load           = 2'(state) + 2'(inflight) - 2'(pop_out);
        o_fifo_read_en = !i_reset && !i_flush && !i_fifo_empty && load < 2'd2;
        capture        = (READ_LATENCY == 1) ? inflight : o_fifo_read_en;
        after          = 2'(state) - 2'(pop_out);
        head_n         = (capture && after == 2'd0) ? i_fifo_data : pop_out ? tail : head;
        tail_n         = (capture && after == 2'd1) ? i_fifo_data : tail;
    end
    // buffer entries and the one-deep in-flight marker for registered-read FIFOs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= (READ_LATENCY == 1) && o_fifo_read_en;
            if (!i_flush) begin
                head <= head_n;
                tail <= tail_n;
            end
        end
    end
    // delivered-word counter; a transfer coinciding with flush is not counted
    always_ff @(posedge i_clk) begin
        if (i_reset) o_count <= '0;
        else if (pop_out && !i_flush) o_count <= o_count + 1'b1;
    end
`ifdef FIFO_READER_STATS_EN
    // saturating count of cycles the consumer waited on an empty buffer
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) o_starve_cycles <= '0;
        else if (i_ready && !o_valid && !(&o_starve_cycles)) o_starve_cycles <= o_starve_cycles + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench running a latency-0 and a latency-1 reader on shared stimulus.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst, flush, ready, fin;
    int push_n;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;

    task automatic check(input int lane, input bit ok, input string name, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL lane%0d %s: got %0h expected %0h at %0t", lane, name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int CW = g ? 4 : 16;
        logic [7:0] fdata, odata;
        logic fempty, ren, valid;
        logic [CW-1:0] cnt_o;
        logic [7:0] q[$];
        logic [7:0] expq[$];
`ifdef FIFO_READER_STATS_EN
        logic [CW-1:0] starve_o;
`endif
        fifo_stream_reader #(.WORD_LENGTH(8), .READ_LATENCY(g), .COUNT_WIDTH(CW)) dut (
            .i_clk(clk), .i_reset(rst), .i_fifo_data(fdata), .i_fifo_empty(fempty),
            .o_fifo_read_en(ren), .o_data(odata), .o_valid(valid), .i_ready(ready),
            .i_flush(flush), .o_count(cnt_o)
`ifdef FIFO_READER_STATS_EN
            , .o_starve_cycles(starve_o)
`endif
        );

        initial begin
            logic [7:0] nxt, held, w;
            int cnt, starve, streak, qn;
            bit hold, was_rst, popped, xfer;
            nxt = 8'hA5; cnt = 0; starve = 0; streak = 0;
            hold = 0; was_rst = 0; w = 0; held = 0;
            fdata = 8'h00; fempty = 1'b1;
            forever begin
                @(negedge clk);
                if (was_rst) begin
                    check(g, valid == 1'b0, "reset_valid", valid, 0);
                    check(g, odata == 8'h00, "reset_data", odata, 0);
                end
                check(g, cnt_o == CW'(cnt), "count", cnt_o, cnt);
`ifdef FIFO_READER_STATS_EN
                check(g, starve_o == CW'(starve), "starve", starve_o, starve);
`endif
                if (hold) begin
                    check(g, valid == 1'b1, "hold_valid", valid, 1);
                    check(g, odata == held, "hold_data", odata, held);
                end
                if (streak >= g + 1) check(g, valid == 1'b1, "latency_valid", valid, 1);
                check(g, expq.size() <= 2, "overpop_depth", expq.size(), 2);
                qn = q.size();
                if (ren) check(g, qn > 0 && !rst && !flush, "read_en_legal", ren, 0);
                xfer = valid && ready;
                popped = ren && qn > 0;
                if (popped) w = q.pop_front();
                if (rst || flush) expq.delete();
                else begin
                    if (xfer) begin
                        if (expq.size() == 0) check(g, 1'b0, "spurious_word", odata, 0);
                        else begin
                            logic [7:0] e;
                            e = expq.pop_front();
                            check(g, odata == e, "data_order", odata, e);
                        end
                        cnt = (cnt + 1) % (1 << CW);
                    end
                    if (popped) expq.push_back(w);
                end
                if (rst) cnt = 0;
                if (rst || flush) starve = 0;
                else if (ready && !valid && starve != (1 << CW) - 1) starve++;
                streak = (qn > 0 && ready && !rst && !flush) ? streak + 1 : 0;
                hold = valid && !ready && !rst && !flush;
                held = odata;
                was_rst = rst;
                if (fin) check(g, expq.size() == 0 && q.size() == 0, "drain_empty", expq.size() + q.size(), 0);
                @(posedge clk);
                #2;
                repeat (push_n) begin
                    q.push_back(nxt);
                    nxt++;
                end
                fempty = q.size() == 0;
                if (g == 0) fdata = q.size() > 0 ? q[0] : 8'($urandom);
                else fdata = popped ? w : 8'($urandom);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ready = 1'b1; push_n = 0; fin = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        push_n = 1; step(); push_n = 0;
        repeat (6) step();
        push_n = 8; step(); push_n = 0;
        repeat (15) step();
        ready = 1'b0; push_n = 5; step(); push_n = 0;
        repeat (10) step();
        ready = 1'b1;
        repeat (10) step();
        push_n = 6; step(); push_n = 0;
        step(); step();
        flush = 1'b1; step(); flush = 1'b0;
        repeat (15) step();
        repeat (3000) begin
            ready  = $urandom_range(0, 3) != 0;
            push_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            flush  = $urandom_range(0, 24) == 0;
            rst    = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 1'b0; flush = 1'b0; ready = 1'b1; push_n = 0;
        repeat (500) step();
        fin = 1'b1; step(); fin = 1'b0;
        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
